// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app-port arbiter:
// command codes, sequencer states and default widths.
package ddr3_app_pkg;

  localparam int ADDR_W_DEF   = 28;
  localparam int DATA_W_DEF   = 128;
  localparam int MASK_W_DEF   = 16;
  localparam int RD_DEPTH_DEF = 4;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    CMD   = 2'd2
  } state_t;

endpackage

// File: rtl/ddr3_rd_id_fifo.sv
// Read-ID FIFO: records which port issued each outstanding read.
// Ports: push/push_id in, pop in, full/empty/head out.
module ddr3_rd_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_id;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a DDR3 app port.
// Ports: req_* (two requesters), rsp_* (read returns), cmd/wr/rd app side.
module ddr3_app_arbiter
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MASK_W   = MASK_W_DEF,
  parameter int RD_DEPTH = RD_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [MASK_W-1:0] req_wmask0,
  input  logic [MASK_W-1:0] req_wmask1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_calib_complete,
  input  logic              cmd_ready,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [5:0]        app_burst_number,
  input  logic              wr_data_rdy,
  output logic [DATA_W-1:0] wr_data,
  output logic [MASK_W-1:0] wr_data_mask,
  output logic              wr_data_en,
  output logic              wr_data_end,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic              rd_err
);

  state_t state;
  state_t state_nx;

  logic              ptr;
  logic              h_we;
  logic              h_port;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [MASK_W-1:0] h_wmask;

  logic [1:0] elig;
  logic       gnt;
  logic       gnt_vld;
  logic       push;
  logic       full;
  logic       empty;
  logic       head;
  logic       beat_ok;

  // reads are held back only while the ID FIFO has no room
  assign elig[0] = req_valid[0] && (req_we[0] || !full);
  assign elig[1] = req_valid[1] && (req_we[1] || !full);

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      elig == 2'b11: gnt = ptr;
      elig == 2'b10: gnt = 1'b1;
      default:       gnt = 1'b0;
    endcase
  end

  assign gnt_vld = (state == IDLE) && init_calib_complete && (|elig);

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    cmd_en     = 1'b0;
    wr_data_en = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt] = 1'b1;
          state_nx = req_we[gnt] ? WDATA : CMD;
        end
      end
      WDATA: begin
        wr_data_en = 1'b1;
        if (wr_data_rdy) state_nx = CMD;
      end
      CMD: begin
        cmd_en = 1'b1;
        if (cmd_ready) begin
          state_nx = IDLE;
          push     = !h_we;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      h_we    <= 1'b0;
      h_port  <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
      h_wmask <= '0;
    end else begin
      state <= state_nx;
      if (gnt_vld) begin
        ptr     <= ~gnt;
        h_port  <= gnt;
        h_we    <= req_we[gnt];
        h_addr  <= gnt ? req_addr1 : req_addr0;
        h_wdata <= gnt ? req_wdata1 : req_wdata0;
        h_wmask <= gnt ? req_wmask1 : req_wmask0;
      end
    end
  end

  // code driven only while a command is valid so idle/reset shows 0
  assign cmd              = (cmd_en && !h_we) ? CMD_RD : CMD_WR;
  assign addr             = h_addr;
  assign app_burst_number = 6'd0;
  assign wr_data          = h_wdata;
  assign wr_data_mask     = h_wmask;
  assign wr_data_end      = wr_data_en;

  ddr3_rd_id_fifo #(
    .DEPTH(RD_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_id(h_port),
    .pop    (rd_data_valid),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

  assign beat_ok = rd_data_valid && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rd_err    <= 1'b0;
    end else begin
      rsp_valid <= {beat_ok && head, beat_ok && !head};
      if (beat_ok) rsp_rdata <= rd_data;
      if (rd_data_valid && empty) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed plus randomized bench for ddr3_app_arbiter with a
// transaction-level reference model.
module tb_ddr3_app_arbiter;

  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, addr;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, wr_data, rd_data;
  logic [MW-1:0] req_wmask0, req_wmask1, wr_data_mask;
  logic          init_calib_complete, cmd_ready, cmd_en;
  logic          wr_data_rdy, wr_data_en, wr_data_end;
  logic          rd_data_valid, rd_err;
  logic [2:0]    cmd;
  logic [5:0]    app_burst_number;

  always #5 clk = ~clk;

  ddr3_app_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_addr0          (req_addr0),
    .req_addr1          (req_addr1),
    .req_wdata0         (req_wdata0),
    .req_wdata1         (req_wdata1),
    .req_wmask0         (req_wmask0),
    .req_wmask1         (req_wmask1),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .init_calib_complete(init_calib_complete),
    .cmd_ready          (cmd_ready),
    .cmd                (cmd),
    .cmd_en             (cmd_en),
    .addr               (addr),
    .app_burst_number   (app_burst_number),
    .wr_data_rdy        (wr_data_rdy),
    .wr_data            (wr_data),
    .wr_data_mask       (wr_data_mask),
    .wr_data_en         (wr_data_en),
    .wr_data_end        (wr_data_end),
    .rd_data            (rd_data),
    .rd_data_valid      (rd_data_valid),
    .rd_err             (rd_err)
  );

  int errors = 0;
  int checks = 0;

  // model: one transaction in service at a time, queue of read owners
  bit            m_busy, m_ddone, m_we, m_err;
  int            m_port, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rsp_data;
  logic [MW-1:0] m_mask;
  logic [1:0]    m_rsp;
  int            q[$];

  logic [1:0] last_grant;
  int         grant_log[$];
  int         rsp_log[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ddone = 0; m_we = 0; m_err = 0;
    m_port = 0; m_ptr = 0; m_rsp = '0;
    m_addr = '0; m_data = '0; m_mask = '0; m_rsp_data = '0;
    q.delete();
  endtask

  task automatic check_cycle();
    int g;
    int p;
    bit e0, e1;
    logic [1:0] er, nrsp;
    g  = -1;
    er = '0;
    if (!m_busy) begin
      e0 = init_calib_complete && req_valid[0] && (req_we[0] || q.size() < DEPTH);
      e1 = init_calib_complete && req_valid[1] && (req_we[1] || q.size() < DEPTH);
      if (e0 && e1) g = m_ptr;
      else if (e0) g = 0;
      else if (e1) g = 1;
      if (g >= 0) er[g] = 1'b1;
    end
    chk("req_ready", DW'(req_ready), DW'(er));
    chk("cmd_en", DW'(cmd_en), DW'(m_busy && m_ddone));
    chk("wr_data_en", DW'(wr_data_en), DW'(m_busy && !m_ddone));
    chk("wr_data_end", DW'(wr_data_end), DW'(m_busy && !m_ddone));
    if (m_busy && !m_ddone) begin
      chk("wr_data", wr_data, m_data);
      chk("wr_data_mask", DW'(wr_data_mask), DW'(m_mask));
    end
    if (m_busy && m_ddone) begin
      chk("cmd", DW'(cmd), DW'(m_we ? 3'b000 : 3'b001));
      chk("addr", DW'(addr), DW'(m_addr));
    end
    chk("rsp_valid", DW'(rsp_valid), DW'(m_rsp));
    if (m_rsp != 2'b00) chk("rsp_rdata", rsp_rdata, m_rsp_data);
    chk("rd_err", DW'(rd_err), DW'(m_err));
    chk("burst", DW'(app_burst_number), DW'(0));
    if (rsp_valid == 2'b01) rsp_log.push_back(0);
    if (rsp_valid == 2'b10) rsp_log.push_back(1);
    last_grant = er;
    if (g >= 0) grant_log.push_back(g);
    // effects of the coming clock edge; pop sees the pre-edge queue
    nrsp = '0;
    if (rd_data_valid) begin
      if (q.size() > 0) begin
        p = q.pop_front();
        nrsp[p] = 1'b1;
        m_rsp_data = rd_data;
      end else begin
        m_err = 1;
      end
    end
    m_rsp = nrsp;
    if (m_busy) begin
      if (m_ddone) begin
        if (cmd_ready) begin
          m_busy = 0;
          if (!m_we) q.push_back(m_port);
        end
      end else if (wr_data_rdy) begin
        m_ddone = 1;
      end
    end else if (g >= 0) begin
      m_busy  = 1;
      m_port  = g;
      m_we    = req_we[g];
      m_ddone = !req_we[g];
      m_addr  = g ? req_addr1 : req_addr0;
      m_data  = g ? req_wdata1 : req_wdata0;
      m_mask  = g ? req_wmask1 : req_wmask0;
      m_ptr   = 1 - g;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (rst_n) check_cycle();
    else last_grant = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int port, input int lim);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_grant[port] && n < lim);
    chk("grant_wait", DW'(last_grant[port]), DW'(1));
  endtask

  task automatic apply_reset();
    rst_n = 0;
    req_valid = '0; req_we = '0;
    init_calib_complete = 0; cmd_ready = 0;
    wr_data_rdy = 0; rd_data_valid = 0;
    model_reset();
    cyc();
    cyc();
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_cmd_en", DW'(cmd_en), DW'(0));
    chk("rst_cmd", DW'(cmd), DW'(0));
    chk("rst_addr", DW'(addr), DW'(0));
    chk("rst_wr_en", DW'({wr_data_en, wr_data_end}), DW'(0));
    chk("rst_wr_data", wr_data, DW'(0));
    chk("rst_rsp", DW'(rsp_valid), DW'(0));
    chk("rst_rdata", rsp_rdata, DW'(0));
    chk("rst_rd_err", DW'(rd_err), DW'(0));
    chk("rst_burst", DW'(app_burst_number), DW'(0));
    rst_n = 1;
  endtask

  initial begin
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    req_wmask0 = '0; req_wmask1 = '0;
    rd_data = '0;
    apply_reset();

    // calibration gate
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 28'h40;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("calib_ready", DW'(req_ready), DW'(0));
      chk("calib_cmd_en", DW'(cmd_en), DW'(0));
    end
    init_calib_complete = 1;
    cyc();
    chk("calib_grant", DW'(last_grant), DW'(2'b01));
    req_valid = '0; cmd_ready = 1;
    cyc();
    cmd_ready = 0; rd_data_valid = 1; rd_data = {4{32'hCAFE0001}};
    cyc();
    rd_data_valid = 0;
    cyc();

    // write with data-path back-pressure
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 28'h100;
    req_wdata0 = {16{8'hA5}}; req_wmask0 = 16'h00F0;
    wait_grant(0, 4);
    req_valid = '0; req_we = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold", DW'(wr_data_en), DW'(1));
      cyc();
    end
    wr_data_rdy = 1;
    chk("wr_accept_cycle", DW'(wr_data_en), DW'(1));
    cyc();
    wr_data_rdy = 0;
    chk("wr_cmd_en", DW'(cmd_en), DW'(1));
    chk("wr_cmd", DW'(cmd), DW'(3'b000));
    chk("wr_addr", DW'(addr), DW'(28'h100));
    chk("wr_en_off", DW'(wr_data_en), DW'(0));
    cmd_ready = 1;
    cyc();
    cmd_ready = 0;
    chk("wr_cmd_done", DW'(cmd_en), DW'(0));

    // alternating reads from both ports
    apply_reset();
    init_calib_complete = 1; cmd_ready = 1; wr_data_rdy = 1;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = 28'h200; req_addr1 = 28'h300;
    grant_log.delete();
    for (int i = 0; i < 20 && grant_log.size() < 4; i++) cyc();
    req_valid = '0;
    cyc();
    chk("rr_count", DW'(grant_log.size()), DW'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", DW'(grant_log[i]), DW'(i % 2));
    rsp_log.delete();
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1;
      rd_data = {4{32'hD0000000 + 32'(i)}};
      cyc();
    end
    rd_data_valid = 0;
    cyc();
    chk("rsp_count", DW'(rsp_log.size()), DW'(4));
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      chk("rsp_order", DW'(rsp_log[i]), DW'(i % 2));

    // ID FIFO full blocks reads only
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 28'h500;
    grant_log.delete();
    for (int i = 0; i < 16; i++) cyc();
    chk("full_reads", DW'(grant_log.size()), DW'(4));
    chk("full_blocked", DW'(req_ready), DW'(0));
    req_valid = 2'b11; req_we = 2'b10; req_addr1 = 28'h600;
    req_wdata1 = {8{16'h5A3C}}; req_wmask1 = 16'h8001;
    wait_grant(1, 4);
    req_valid = 2'b01; req_we = 2'b00;
    for (int i = 0; i < 4; i++) cyc();
    chk("full_still_blocked", DW'(grant_log.size()), DW'(5));
    rd_data_valid = 1; rd_data = {4{32'h11112222}};
    cyc();
    rd_data_valid = 0;
    wait_grant(0, 4);
    req_valid = '0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1;
      rd_data = {4{32'hE0000000 + 32'(i)}};
      cyc();
    end
    rd_data_valid = 0;
    cyc();

    // orphan read beat
    chk("err_before", DW'(rd_err), DW'(0));
    rd_data_valid = 1;
    cyc();
    rd_data_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("err_sticky", DW'(rd_err), DW'(1));
      chk("err_no_rsp", DW'(rsp_valid), DW'(0));
    end

    // reset in the middle of a stalled command
    apply_reset();
    init_calib_complete = 1; cmd_ready = 1;
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 28'h700;
    wait_grant(0, 4);
    req_valid = '0;
    cyc();
    cmd_ready = 0; req_valid = 2'b01;
    wait_grant(0, 4);
    req_valid = '0;
    cyc();
    chk("mid_cmd_en", DW'(cmd_en), DW'(1));
    #2;
    rst_n = 0;
    #1;
    chk("async_cmd_en", DW'(cmd_en), DW'(0));
    model_reset();
    cyc();
    rst_n = 1; cmd_ready = 1;
    rd_data_valid = 1; rd_data = {4{32'hBADBAD00}};
    cyc();
    rd_data_valid = 0;
    cyc();
    chk("post_rst_err", DW'(rd_err), DW'(1));
    req_valid = 2'b11; req_we = 2'b00;
    cyc();
    chk("post_rst_ptr", DW'(last_grant), DW'(2'b01));
    req_valid = '0;
    cyc();
    rd_data_valid = 1;
    cyc();
    rd_data_valid = 0;
    cyc();

    // randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_we[i] = 1'($urandom);
          if (i == 0) begin
            req_addr0 = AW'($urandom);
            req_wdata0 = {$urandom, $urandom, $urandom, $urandom};
            req_wmask0 = MW'($urandom);
          end else begin
            req_addr1 = AW'($urandom);
            req_wdata1 = {$urandom, $urandom, $urandom, $urandom};
            req_wmask1 = MW'($urandom);
          end
        end
      end
      init_calib_complete = ($urandom % 20) != 0;
      cmd_ready = ($urandom % 4) != 0;
      wr_data_rdy = ($urandom % 3) != 0;
      rd_data_valid = (q.size() > 0) && ($urandom % 3 == 0);
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      req_valid = req_valid & ~last_grant;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
